// File: rtl/maze_pkg.sv
// Shared types and constants for the maze pixel-to-cell writer.
package maze_pkg;

  localparam int ROW_STRIDE = 16;
  localparam int DEF_XSIZE  = 8;
  localparam int DEF_YSIZE  = 6;
  localparam int DEF_BOX    = 4;
  localparam int DEF_THRESH = 8;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  // Row stride of 16 makes the address simply {cy, cx}.
  function automatic logic [7:0] cell_addr(input logic [3:0] cy, input logic [3:0] cx);
    return 8'(int'(cy) * ROW_STRIDE + int'(cx));
  endfunction

endpackage

// File: rtl/maze_box_accum.sv
// In-box pixel position tracking, coordinate check and ones counting for one cell.
module maze_box_accum
  import maze_pkg::*;
#(
  parameter int BOX    = DEF_BOX,
  parameter int THRESH = DEF_THRESH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       take,
  input  logic       drop,
  input  logic [3:0] cx,
  input  logic [3:0] cy,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic       pix_val,
  output logic       match,
  output logic       box_last,
  output logic       vote
);

  localparam int         LOG_BOX = $clog2(BOX);
  localparam logic [2:0] PMAX    = 3'(BOX - 1);
  localparam logic [6:0] THR     = 7'(THRESH);

  logic [2:0] px;
  logic [2:0] py;
  logic [6:0] ones;
  logic [6:0] ones_sum;
  logic [7:0] exp_x;
  logic [7:0] exp_y;

  always_comb begin
    exp_x    = 8'({4'd0, cx} << LOG_BOX) + {5'd0, px};
    exp_y    = 8'({4'd0, cy} << LOG_BOX) + {5'd0, py};
    match    = (pix_x == exp_x) && (pix_y == exp_y);
    box_last = (px == PMAX) && (py == PMAX);
    // Vote includes the pixel being accepted this cycle.
    ones_sum = ones + {6'd0, pix_val};
    vote     = (ones_sum >= THR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px   <= '0;
      py   <= '0;
      ones <= '0;
    end else if (drop || (take && box_last)) begin
      px   <= '0;
      py   <= '0;
      ones <= '0;
    end else if (take) begin
      ones <= ones_sum;
      if (px == PMAX) begin
        px <= '0;
        py <= py + 3'd1;
      end else begin
        px <= px + 3'd1;
      end
    end
  end

endmodule

// File: rtl/maze_path_in.sv
// Box-ordered pixel stream to maze RAM writer with per-cell majority vote.
// Optional power-up clear of every cell is enabled by MAZE_PATH_IN_CLEAR_EN.
module maze_path_in
  import maze_pkg::*;
#(
  parameter int XSIZE  = DEF_XSIZE,
  parameter int YSIZE  = DEF_YSIZE,
  parameter int BOX    = DEF_BOX,
  parameter int THRESH = DEF_THRESH
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic       pix_val,
  output logic       wr_en,
  output logic [7:0] wr_address,
  output logic       wr_data,
  output logic       frame_done,
  output logic       sync_err,
  output logic [1:0] fsm_state
);

  // Handshake: a sample transfers on a rising edge where pix_valid && pix_ready;
  // the source must hold the sample stable until then.

  localparam logic [3:0] CX_MAX = 4'(XSIZE - 1);
  localparam logic [3:0] CY_MAX = 4'(YSIZE - 1);

`ifdef MAZE_PATH_IN_CLEAR_EN
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  localparam state_t RESET_STATE = ST_ACCEPT;
`endif

  state_t     state;
  state_t     next_state;
  logic [3:0] cx;
  logic [3:0] cy;
  logic [3:0] cx_next;
  logic [3:0] cy_next;
  logic       hs;
  logic       good;
  logic       bad;
  logic       match;
  logic       box_last;
  logic       vote;
  logic       last_cell;
  logic       advance;

  maze_box_accum #(
    .BOX    (BOX),
    .THRESH (THRESH)
  ) u_accum (
    .clk      (clk),
    .resetn   (resetn),
    .take     (good),
    .drop     (bad),
    .cx       (cx),
    .cy       (cy),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_val  (pix_val),
    .match    (match),
    .box_last (box_last),
    .vote     (vote)
  );

  assign fsm_state = state;

  always_comb begin
    hs        = pix_valid && pix_ready;
    good      = hs && match;
    bad       = hs && !match;
    last_cell = (cx == CX_MAX) && (cy == CY_MAX);
    advance   = (state == ST_WRITE) || (state == ST_CLEAR);
    cx_next   = cx + 4'd1;
    cy_next   = cy;
    if (cx == CX_MAX) begin
      cx_next = '0;
      cy_next = (cy == CY_MAX) ? 4'd0 : cy + 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_ACCEPT: if (good && box_last) next_state = ST_WRITE;
      ST_WRITE:  next_state = ST_ACCEPT;
`ifdef MAZE_PATH_IN_CLEAR_EN
      ST_CLEAR:  if (last_cell) next_state = ST_ACCEPT;
`else
      ST_CLEAR:  next_state = ST_ACCEPT;
`endif
      default:   next_state = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RESET_STATE;
      cx         <= '0;
      cy         <= '0;
      pix_ready  <= 1'b0;
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (advance) begin
        cx <= cx_next;
        cy <= cy_next;
      end
      // Ready is held low for one extra cycle after CLEAR so it never overlaps a clear write.
      pix_ready  <= (next_state == ST_ACCEPT) && (state != ST_CLEAR);
      sync_err   <= bad;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (state == ST_ACCEPT && good && box_last) begin
        wr_en      <= 1'b1;
        wr_address <= cell_addr(cy, cx);
        wr_data    <= vote;
        frame_done <= last_cell;
      end
`ifdef MAZE_PATH_IN_CLEAR_EN
      if (state == ST_CLEAR) begin
        wr_en      <= 1'b1;
        wr_address <= cell_addr(cy, cx);
        wr_data    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_maze_path_in.sv
// Randomized directed bench for maze_path_in against a cell-level reference model.
module tb_maze_path_in;

  localparam int XS = 8;
  localparam int YS = 6;
  localparam int BX = 4;
  localparam int TH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] pix_x = '0;
  logic [7:0] pix_y = '0;
  logic       pix_val = 1'b0;
  logic       wr_en;
  logic [7:0] wr_address;
  logic       wr_data;
  logic       frame_done;
  logic       sync_err;
  logic [1:0] fsm_state;

  int tests = 0;
  int fails = 0;
  int sync_seen = 0;
  int sync_exp = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  maze_path_in #(.XSIZE(XS), .YSIZE(YS), .BOX(BX), .THRESH(TH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_val    (pix_val),
    .wr_en      (wr_en),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .fsm_state  (fsm_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected {frame_done, address, data}
  always @(negedge clk) begin
    if (resetn) begin
      if (sync_err === 1'b1) sync_seen++;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {6'd0, frame_done, wr_address, wr_data}, 16'hffff);
        end else begin
          mon_e = exp_q.pop_front();
          check("write", {6'd0, frame_done, wr_address, wr_data}, {6'd0, mon_e});
        end
      end
    end
  end

  function automatic logic [9:0] exp_write(input int cx, input int cy, input logic data);
    logic last;
    last = (cx == XS - 1) && (cy == YS - 1);
    return {last, 8'(cy * 16 + cx), data};
  endfunction

  task automatic do_reset();
    int n = 0;
    resetn = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {15'd0, pix_ready}, 16'd0);
    check("rst_outputs", {5'd0, wr_en, wr_address, wr_data, frame_done, sync_err}, 16'd0);
`ifdef MAZE_PATH_IN_CLEAR_EN
    for (int k = 0; k < XS * YS; k++) exp_q.push_back({1'b0, 8'((k / XS) * 16 + (k % XS)), 1'b0});
    resetn = 1'b1;
    while (!pix_ready && n < 200) begin
      @(posedge clk);
      #1;
      if (!pix_ready && n < XS * YS) check("ready_low_in_clear", {15'd0, pix_ready}, 16'd0);
      n++;
    end
    check("clear_done", 16'(exp_q.size()), 16'd0);
`else
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {15'd0, pix_ready}, 16'd1);
`endif
  endtask

  // Driver: present one sample, wait (bounded) for ready, return just after the transfer edge
  task automatic send_pixel(input int x, input int y, input logic v);
    int n = 0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    @(negedge clk);
    pix_x = 8'(x);
    pix_y = 8'(y);
    pix_val = v;
    pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("handshake", {15'd0, (n < 100)}, 16'd1);
    if (n < 100) begin
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  // Reference: a cell writes 1 when its pixel ones count reaches the threshold
  task automatic send_cell(input int cx, input int cy, input int n_ones);
    logic v[BX*BX];
    logic t;
    int cnt = 0;
    int j;
    for (int i = 0; i < BX * BX; i++)
      v[i] = (n_ones < 0) ? 1'($urandom_range(0, 1)) : (i < n_ones);
    if (n_ones >= 0) begin
      for (int i = BX * BX - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = v[i]; v[i] = v[j]; v[j] = t;
      end
    end
    for (int i = 0; i < BX * BX; i++) cnt += int'(v[i]);
    exp_q.push_back(exp_write(cx, cy, cnt >= TH));
    for (int py = 0; py < BX; py++)
      for (int px = 0; px < BX; px++)
        send_pixel(cx * BX + px, cy * BX + py, v[py * BX + px]);
    check("write_latency", {15'd0, wr_en}, 16'd1);
    check("ready_low_in_write", {15'd0, pix_ready}, 16'd0);
  endtask

  initial begin
    do_reset();

    send_cell(0, 0, 16);
    @(posedge clk);
    #1;
    check("wr_en_one_cycle", {15'd0, wr_en}, 16'd0);

    send_cell(1, 0, 8);
    send_cell(2, 0, 7);

    for (int k = 3; k < XS * YS; k++) send_cell(k % XS, k / XS, -1);
    check("frame_done_last", {15'd0, frame_done}, 16'd1);
    send_cell(0, 0, -1);
    check("frame_done_clear", {15'd0, frame_done}, 16'd0);

    // Reset in the middle of cell (1,0): nothing written, restart at cell (0,0)
    for (int i = 0; i < 10; i++) send_pixel(BX + i % BX, i / BX, 1'b1);
    resetn = 1'b0;
    #1;
    check("async_rst_ready", {15'd0, pix_ready}, 16'd0);
    check("async_rst_outputs", {5'd0, wr_en, wr_address, wr_data, frame_done, sync_err}, 16'd0);
    do_reset();

    // Wrong coordinate at box start
    send_pixel(5, 0, 1'b1);
    sync_exp++;
    check("sync_err_pulse", {15'd0, sync_err}, 16'd1);
    check("no_write_on_err", {15'd0, wr_en}, 16'd0);
    @(posedge clk);
    #1;
    check("sync_err_one_cycle", {15'd0, sync_err}, 16'd0);
    send_cell(0, 0, -1);

    // Mismatch mid-box must discard the partial ones count
    for (int i = 0; i < 5; i++) send_pixel(BX + i % BX, i / BX, 1'b1);
    send_pixel(0, 0, 1'b1);
    sync_exp++;
    check("sync_err_midbox", {15'd0, sync_err}, 16'd1);
    send_cell(1, 0, 7);

    // Upper coordinate bits take part in the compare
    send_pixel(8'h80 + 2 * BX, 0, 1'b1);
    sync_exp++;
    check("sync_err_highbit", {15'd0, sync_err}, 16'd1);
    send_cell(2, 0, 8);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    check("sync_err_count", 16'(sync_seen), 16'(sync_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
